// File: rtl/nega_pkg.sv
// Shared types and helpers for the negabinary serial adder.
// Optional feature macro: NEGA_SERIAL_EARLY_DONE_EN.
package nega_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Result digit count that holds any sum of two w-digit words.
  function automatic int nega_out_width(input int w);
    return w + 2;
  endfunction

  // Decode the low n digits of a negabinary word to an integer.
  function automatic longint nega_to_int(
    input logic [63:0] v,
    input int          n
  );
    longint acc;
    longint wgt;
    acc = 0;
    wgt = 1;
    for (int i = 0; i < n; i++) begin
      if (v[i]) acc = acc + wgt;
      wgt = -2 * wgt;
    end
    return acc;
  endfunction

endpackage

// File: rtl/nega_serial_adder_slice.sv
// One negabinary digit: t = a + b + cp - cn, with dual carries.
// Used by nega_serial_adder (macro NEGA_SERIAL_EARLY_DONE_EN n/a here).
module nega_digit_slice (
  input  logic a,
  input  logic b,
  input  logic cp,
  input  logic cn,
  output logic s,
  output logic c_out_pos,
  output logic c_out_neg
);

  logic [2:0] pos_sum;

  // Parity gives the digit; carries flag t = -1 and t >= 2.
  always_comb begin
    pos_sum   = {2'b00, a} + {2'b00, b} + {2'b00, cp};
    s         = a ^ b ^ cp ^ cn;
    c_out_pos = cn & (pos_sum == 3'd0);
    c_out_neg = cn ? (pos_sum == 3'd3) : (pos_sum >= 3'd2);
  end

endmodule

// File: rtl/nega_serial_adder.sv
// Bit-serial negabinary word adder, LSB first, one digit per cycle.
// Optional macro NEGA_SERIAL_EARLY_DONE_EN ends RUN once nothing is left.
module nega_serial_adder
  import nega_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = nega_out_width(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_sum,
  output logic                 busy
);

  localparam int CW = $clog2(OUT_WIDTH);

  state_t               state;
  logic [OUT_WIDTH-1:0] sh_a;
  logic [OUT_WIDTH-1:0] sh_b;
  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] next_acc;
  logic                 carry_pos;
  logic                 carry_neg;
  logic [CW-1:0]        cnt;
  logic                 s;
  logic                 c_out_pos;
  logic                 c_out_neg;
  logic                 last;
  logic                 fin_early;

  nega_digit_slice u_slice (
    .a         (sh_a[0]),
    .b         (sh_b[0]),
    .cp        (carry_pos),
    .cn        (carry_neg),
    .s         (s),
    .c_out_pos (c_out_pos),
    .c_out_neg (c_out_neg)
  );

  assign last = (cnt == CW'(OUT_WIDTH - 1));

`ifdef NEGA_SERIAL_EARLY_DONE_EN
  assign fin_early = (sh_a == '0) && (sh_b == '0)
                   && !carry_pos && !carry_neg;
`else
  assign fin_early = 1'b0;
`endif

  // Place the current digit at its own weight; unrun digits stay 0.
  always_comb begin
    next_acc      = acc;
    next_acc[cnt] = s;
  end

  // Handshake FSM plus the serial datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      busy      <= 1'b0;
      carry_pos <= 1'b0;
      carry_neg <= 1'b0;
      cnt       <= '0;
      sh_a      <= '0;
      sh_b      <= '0;
      acc       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sh_a      <= OUT_WIDTH'(in_a);
            sh_b      <= OUT_WIDTH'(in_b);
            carry_pos <= 1'b0;
            carry_neg <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (fin_early) begin
            out_sum   <= acc;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            acc       <= next_acc;
            sh_a      <= sh_a >> 1;
            sh_b      <= sh_b >> 1;
            carry_pos <= c_out_pos;
            carry_neg <= c_out_neg;
            cnt       <= cnt + 1'b1;
            if (last) begin
              out_sum   <= next_acc;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nega_serial_adder.sv
// Self-checking bench for nega_serial_adder against an integer model.
// Latency check assumes NEGA_SERIAL_EARLY_DONE_EN is undefined.
module tb_nega_serial_adder;
  import nega_pkg::*;

  localparam int W  = 8;
  localparam int OW = W + 2;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_sum;
  logic          busy;

  int compared;
  int mismatched;

  nega_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plain weighted-digit decode, independent of the package helper.
  function automatic longint dec(input logic [63:0] v, input int n);
    longint r;
    longint p;
    r = 0;
    p = 1;
    for (int i = 0; i < n; i++) begin
      if (v[i]) r += p;
      p *= -2;
    end
    return r;
  endfunction

  // Integer to negabinary by repeated division by -2.
  function automatic logic [OW-1:0] enc(input longint v);
    logic [OW-1:0] r;
    longint x;
    longint d;
    r = '0;
    x = v;
    for (int i = 0; i < OW; i++) begin
      d = x & 64'sd1;
      r[i] = d[0];
      x = (x - d) / -2;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run one operation; optionally hold DONE with out_ready low.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                    input int hold, output logic [OW-1:0] res);
    int cyc;
    longint want;
    @(negedge clk);
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("busy_run", busy, 1);
    chk("ready_run", in_ready, 0);
    cyc = 1;
    while (!out_valid && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("valid_seen", out_valid, 1);
`ifndef NEGA_SERIAL_EARLY_DONE_EN
    chk("latency", 64'(cyc), 64'(OW + 1));
`endif
    res  = out_sum;
    want = dec(64'(a), W) + dec(64'(b), W);
    chk("sum_enc", out_sum, 64'(enc(want)));
    chk("sum_val", 64'(nega_to_int(64'(out_sum), OW)), 64'(want));
    chk("carry_pos_end", dut.carry_pos, 0);
    chk("carry_neg_end", dut.carry_neg, 0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      in_a     = a ^ 8'h5A;
      in_b     = ~b;
      in_valid = (k % 3 == 0);
      @(posedge clk);
      #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", out_sum, 64'(res));
      chk("hold_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("drop_valid", out_valid, 0);
    chk("idle_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_hold_sum", out_sum, 64'(res));
  endtask

  initial begin
    logic [OW-1:0] r;
    logic [W-1:0]  ra;
    logic [W-1:0]  rb;
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    out_ready  = 1'b0;
    #12;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    op(8'h01, 8'h01, 0, r);
    chk("one_plus_one", r, 10'h006);
    op(8'h01, 8'h03, 0, r);
    chk("one_plus_neg1", r, 10'h000);
    op(8'h55, 8'h55, 0, r);
    chk("max_pos", r, 10'h1FE);
    op(8'hAA, 8'hAA, 0, r);
    chk("max_neg", r, 10'h3FC);
    op(8'h37, 8'hC9, 20, r);

    // Abort mid-RUN with an asynchronous reset.
    @(negedge clk);
    in_a     = 8'h7F;
    in_b     = 8'h3C;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_sum", out_sum, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    op(8'h02, 8'h06, 0, r);
    chk("after_abort", r, 10'h000);
    op(8'h00, 8'h00, 0, r);
    op(8'hFF, 8'hFF, 0, r);

    for (int n = 0; n < 300; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      op(ra, rb, 0, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
